bitmask_to_sorted_seq: RTL and testbench
========================================

Name: bitmask_to_sorted_seq

Overview:
Inverse and downstream partner of the sorted-sequence-to-bitmask stage. It consumes a stream of NUM_ELEMENTS-bit membership masks and emits the set bit positions as ascending IDs, packed densely into NUM_ELEMENTS-lane beats with per-lane keep. Each output beat is full except the final beat of a packet. It sits between bitmask-producing filter stages and ID-consuming gather/lookup stages.

Parameters:
data_t, logic[31:0], ID type; W = $bits(data_t)
NUM_ELEMENTS, 8, mask width and output lane count (N), power of two, >= 2

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
in_data  in  N  membership mask; bit j = ID (base + j)
in_last  in  1  last mask beat of packet
in_valid  in  1  input valid
in_ready  out  1  input ready
out_data  out  N*W  lane i = ID, ascending lane order
out_keep  out  N  lane valid bits, always contiguous from lane 0
out_last  out  1  last beat of packet
out_valid  out  1  output valid
out_ready  in  1  output ready

Behaviour:
- Interface: one clock, clk; reset rst is synchronous, active-high.
- Reset: out_valid=0, out_data=0, out_keep=0, out_last=0, base=0, res_cnt=0, state=RUN. A reset mid-packet discards the residue and any held output beat.
- base: W-bit counter. Advances by N on every accepted non-last beat. Set to 0 on an accepted last beat. Wraps modulo 2^W.
- Residue buffer: res[0..N-2] holds IDs, with count res_cnt in 0..N-1.
- Output register: free when !out_valid || out_ready. A held beat stays stable until out_ready. Unused lanes are driven 0.
- States: RUN, FLUSH.
- RUN:
  - in_ready = output register free (combinational on out_ready).
  - On accept, compact the set bits of in_data in ascending order into p = popcount IDs.
  - Combined list = residue followed by the new IDs; total = res_cnt + p.
  - If total >= N:
    - Emit the first N IDs with keep all ones.
    - out_last = in_last && total==N.
    - Residue = the remaining total-N IDs.
    - If in_last && total>N, go to FLUSH.
  - If total < N and !in_last: update residue, emit nothing.
  - If total < N and in_last:
    - Emit total IDs, keep = low total bits, out_last=1, res_cnt=0.
    - total==0 emits one beat with keep=0, last=1, so packet boundaries are preserved.
- FLUSH:
  - in_ready=0.
  - When the output register is free, emit the residue with keep = low res_cnt bits, out_last=1.
  - Then res_cnt=0 and go to RUN.
- Latency: exactly 1 cycle from input accept to out_valid.
- Throughput: 1 mask beat per cycle, plus at most one stall cycle per packet (FLUSH).
- ID arithmetic: ID = base + j computed in W bits; no overflow detection.

Test Plan:
(All with N=4, W=16.)
1. Single mask 0b1011, in_last=1 -> after 1 cycle: out_data lanes {0,1,3,0}, keep 0111, last=1; base returns to 0.
2. Mask 0b1111 (non-last), then mask 0b0000 (last):
   - Beat {0,1,2,3}, keep 1111, last=0.
   - Then beat keep 0000, last=1.
3. Masks 0b0111, then 0b0111 (last):
   - No output after the first mask (residue {0,1,2}).
   - Then {0,1,2,4}, keep 1111, last=0; in_ready=0 for one cycle.
   - Then {5,6}, keep 0011, last=1.
4. Output held with out_ready=0 for 5 cycles while input is valid:
   - out_* stable, in_ready=0 throughout.
   - After release, all IDs 0..11 arrive in order from masks 1111,1111,1111(last); no loss or duplication.
5. Packet A = 2 masks 0b0001, 0b0001 (last) -> IDs {0,4}. Packet B = 0b0001 (last) -> ID {0}, showing base reset between packets.
6. rst asserted after mask 0b0011 (non-last, residue {0,1}):
   - Next cycle out_valid=0, res_cnt=0.
   - A subsequent mask 0b1000 (last) yields {3}, keep 0001, last=1.

Source files
------------

// File: rtl/bitmask_to_sorted_seq_if.sv
// Stream bundle for the bitmask-to-sorted-ID stage: mask beats in, dense ID beats out.
// The master drives masks and consumes IDs; the slave is the converter.
interface bitmask_to_sorted_seq_if #(
    parameter int NUM_ELEMENTS = 8,
    parameter int W            = 32
);
    logic [NUM_ELEMENTS-1:0]   in_data;
    logic                      in_last;
    logic                      in_valid;
    logic                      in_ready;
    logic [NUM_ELEMENTS*W-1:0] out_data;
    logic [NUM_ELEMENTS-1:0]   out_keep;
    logic                      out_last;
    logic                      out_valid;
    logic                      out_ready;

    modport master (
        output in_data, in_last, in_valid, out_ready,
        input  in_ready, out_data, out_keep, out_last, out_valid
    );

    modport slave (
        input  in_data, in_last, in_valid, out_ready,
        output in_ready, out_data, out_keep, out_last, out_valid
    );
endinterface

// File: rtl/bitmask_to_sorted_seq.sv
// Converts membership masks into ascending IDs packed densely into N-lane beats.
// Partial beats are carried as residue and only emitted short at end of packet.
module bitmask_to_sorted_seq #(
    parameter type data_t       = logic [31:0],
    parameter int  NUM_ELEMENTS = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    bitmask_to_sorted_seq_if.slave bus
);
    localparam int N     = NUM_ELEMENTS;
    localparam int W     = $bits(data_t);
    localparam int IDX_W = $clog2(2 * N);
    localparam int RC_W  = $clog2(N);

    typedef enum logic {RUN, FLUSH} state_t;

    state_t           state_reg, state_next;
    data_t            base_reg, base_next;
    data_t            res_reg [N-1];
    data_t            res_next [N-1];
    logic [RC_W-1:0]  res_cnt_reg, res_cnt_next;
    data_t            lane_reg [N];
    data_t            lane_next [N];
    logic [N-1:0]     keep_reg, keep_next;
    logic             last_reg, last_next;
    logic             valid_reg, valid_next;

    data_t            comb_ids [2*N];
    logic [IDX_W-1:0] total;
    logic             out_free;
    logic             accept;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= RUN;
        end else begin
            state_reg <= state_next;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            base_reg    <= '0;
            res_cnt_reg <= '0;
            keep_reg    <= '0;
            last_reg    <= 1'b0;
            valid_reg   <= 1'b0;
            for (int i = 0; i < N - 1; i++) res_reg[i] <= '0;
            for (int i = 0; i < N; i++) lane_reg[i] <= '0;
        end else begin
            base_reg    <= base_next;
            res_cnt_reg <= res_cnt_next;
            keep_reg    <= keep_next;
            last_reg    <= last_next;
            valid_reg   <= valid_next;
            res_reg     <= res_next;
            lane_reg    <= lane_next;
        end
    end

    always_comb begin
        out_free = !valid_reg || bus.out_ready;
        accept   = (state_reg == RUN) && out_free && bus.in_valid;

        // Residue first, then the new IDs; slots past the total stay zero so
        // unused output lanes and residue entries are always clean.
        for (int i = 0; i < 2 * N; i++) comb_ids[i] = '0;
        for (int i = 0; i < N - 1; i++) begin
            if (RC_W'(i) < res_cnt_reg) comb_ids[i] = res_reg[i];
        end
        total = IDX_W'(res_cnt_reg);
        for (int j = 0; j < N; j++) begin
            if (bus.in_data[j]) begin
                comb_ids[total] = base_reg + data_t'(j);
                total           = total + IDX_W'(1);
            end
        end

        state_next   = state_reg;
        base_next    = base_reg;
        res_next     = res_reg;
        res_cnt_next = res_cnt_reg;
        lane_next    = lane_reg;
        keep_next    = keep_reg;
        last_next    = last_reg;
        valid_next   = out_free ? 1'b0 : valid_reg;

        case (state_reg)
            RUN: begin
                if (accept) begin
                    base_next = bus.in_last ? '0 : base_reg + data_t'(N);
                    if (total >= IDX_W'(N)) begin
                        valid_next = 1'b1;
                        keep_next  = '1;
                        last_next  = bus.in_last && (total == IDX_W'(N));
                        for (int i = 0; i < N; i++) lane_next[i] = comb_ids[i];
                        for (int i = 0; i < N - 1; i++) res_next[i] = comb_ids[N + i];
                        res_cnt_next = RC_W'(total - IDX_W'(N));
                        if (bus.in_last && (total != IDX_W'(N))) state_next = FLUSH;
                    end else if (!bus.in_last) begin
                        for (int i = 0; i < N - 1; i++) res_next[i] = comb_ids[i];
                        res_cnt_next = RC_W'(total);
                    end else begin
                        // Short final beat; total==0 still emits an empty last beat.
                        valid_next = 1'b1;
                        last_next  = 1'b1;
                        for (int i = 0; i < N; i++) begin
                            lane_next[i] = comb_ids[i];
                            keep_next[i] = IDX_W'(i) < total;
                        end
                        for (int i = 0; i < N - 1; i++) res_next[i] = '0;
                        res_cnt_next = '0;
                    end
                end
            end
            FLUSH: begin
                if (out_free) begin
                    valid_next = 1'b1;
                    last_next  = 1'b1;
                    for (int i = 0; i < N; i++) begin
                        lane_next[i] = '0;
                        keep_next[i] = IDX_W'(i) < IDX_W'(res_cnt_reg);
                    end
                    for (int i = 0; i < N - 1; i++) begin
                        lane_next[i] = res_reg[i];
                        res_next[i]  = '0;
                    end
                    res_cnt_next = '0;
                    state_next   = RUN;
                end
            end
            default: state_next = RUN;
        endcase
    end

    genvar gi;
    generate
        for (gi = 0; gi < N; gi++) begin : g_lane
            assign bus.out_data[gi*W +: W] = lane_reg[gi];
        end
    endgenerate

    assign bus.out_keep  = keep_reg;
    assign bus.out_last  = last_reg;
    assign bus.out_valid = valid_reg;
    assign bus.in_ready  = (state_reg == RUN) && out_free;
endmodule

// File: tb/tb_bitmask_to_sorted_seq.sv
// Randomized and directed bench for bitmask_to_sorted_seq (N=4, W=16) with a
// packet-level reference model: IDs of a packet are listed, then chunked into beats.
module tb_bitmask_to_sorted_seq;
    localparam int N = 4;
    localparam int W = 16;

    typedef struct packed {
        logic [N*W-1:0] data;
        logic [N-1:0]   keep;
        logic           last;
    } beat_t;

    logic clk;
    logic rst;
    int   n_tests;
    int   n_fail;
    bit   rand_ready;

    beat_t      exp_q [$];
    logic [3:0] pkt_q [$];

    bitmask_to_sorted_seq_if #(.NUM_ELEMENTS(N), .W(W)) bus ();

    bitmask_to_sorted_seq #(
        .data_t       (logic [W-1:0]),
        .NUM_ELEMENTS (N)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, act, exp);
        end
    endtask

    // Expected beats of one whole packet, from the list of its IDs.
    function automatic void model_packet();
        logic [W-1:0] ids [$];
        int           prev_cnt;
        int           c;
        beat_t        b;
        prev_cnt = 0;
        for (int k = 0; k < pkt_q.size(); k++) begin
            if (k == pkt_q.size() - 1) prev_cnt = ids.size();
            for (int j = 0; j < N; j++)
                if (pkt_q[k][j]) ids.push_back(W'(k * N + j));
        end
        c = ids.size();
        for (int s = 0; s < c; s += N) begin
            b = '0;
            for (int i = 0; i < N; i++) begin
                if (s + i < c) begin
                    b.data[i*W +: W] = ids[s + i];
                    b.keep[i]        = 1'b1;
                end
            end
            b.last = (s + N >= c) && !((c % N == 0) && (c == prev_cnt));
            exp_q.push_back(b);
        end
        if ((c % N == 0) && (c == prev_cnt)) begin
            b      = '0;
            b.last = 1'b1;
            exp_q.push_back(b);
        end
    endfunction

    task automatic drive_mask(input logic [3:0] m, input logic l);
        int guard;
        guard        = 0;
        bus.in_data  = m;
        bus.in_last  = l;
        bus.in_valid = 1'b1;
        @(negedge clk);
        while (!bus.in_ready && guard < 200) begin
            @(negedge clk);
            guard++;
        end
        if (guard >= 200) check("accept timeout", bus.in_ready, 1'b1);
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
    endtask

    task automatic send_packet(input bit idle);
        model_packet();
        for (int k = 0; k < pkt_q.size(); k++) begin
            drive_mask(pkt_q[k], k == pkt_q.size() - 1);
            if (idle && $urandom_range(0, 3) == 0) begin
                @(posedge clk);
                #1;
            end
        end
    endtask

    // Random backpressure, updated just after each rising edge.
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (rand_ready) bus.out_ready = ($urandom_range(0, 99) < 70);
        end
    end

    // Output monitor: scoreboard on each handshake plus hold-stability checks.
    initial begin
        bit             prev_hold;
        logic [N*W-1:0] prev_data;
        logic [N-1:0]   prev_keep;
        logic           prev_last;
        beat_t          e;
        prev_hold = 1'b0;
        forever begin
            @(negedge clk);
            if (rst) begin
                prev_hold = 1'b0;
            end else begin
                if (prev_hold) begin
                    check("hold valid", bus.out_valid, 1'b1);
                    check("hold data", bus.out_data, prev_data);
                    check("hold keep", bus.out_keep, prev_keep);
                    check("hold last", bus.out_last, prev_last);
                end
                if (bus.out_valid && bus.out_ready) begin
                    $display("[TB] beat data=%h keep=%b last=%b", bus.out_data, bus.out_keep, bus.out_last);
                    if (exp_q.size() == 0) begin
                        check("extra beat", 64'(exp_q.size()), 64'd1);
                    end else begin
                        e = exp_q.pop_front();
                        check("beat data", bus.out_data, e.data);
                        check("beat keep", bus.out_keep, e.keep);
                        check("beat last", bus.out_last, e.last);
                    end
                end
                prev_hold = bus.out_valid && !bus.out_ready;
                prev_data = bus.out_data;
                prev_keep = bus.out_keep;
                prev_last = bus.out_last;
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, tests=%0d", n_tests);
        $fatal(1, "watchdog");
    end

    initial begin
        int guard;
        n_tests       = 0;
        n_fail        = 0;
        rand_ready    = 1'b0;
        rst           = 1'b1;
        bus.in_data   = '0;
        bus.in_last   = 1'b0;
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;

        check("reset out_valid", bus.out_valid, 1'b0);
        check("reset out_data", bus.out_data, 64'd0);
        check("reset out_keep", bus.out_keep, 4'd0);
        check("reset out_last", bus.out_last, 1'b0);
        check("reset in_ready", bus.in_ready, 1'b1);

        // Single short packet, one-cycle latency.
        pkt_q = '{4'b1011};
        send_packet(1'b0);
        check("t1 latency valid", bus.out_valid, 1'b1);
        check("t1 data", bus.out_data, 64'h0000_0003_0001_0000);
        check("t1 keep", bus.out_keep, 4'b0111);
        check("t1 last", bus.out_last, 1'b1);

        // Full beat then empty last beat.
        pkt_q = '{4'b1111, 4'b0000};
        send_packet(1'b0);
        check("t2 empty keep", bus.out_keep, 4'b0000);
        check("t2 empty last", bus.out_last, 1'b1);

        // Overflow on the last mask forces a flush cycle.
        pkt_q = '{4'b0111, 4'b0111};
        model_packet();
        drive_mask(4'b0111, 1'b0);
        check("t3 no output", bus.out_valid, 1'b0);
        drive_mask(4'b0111, 1'b1);
        check("t3 full beat", bus.out_data, 64'h0004_0002_0001_0000);
        check("t3 flush in_ready", bus.in_ready, 1'b0);
        @(posedge clk);
        #1;
        check("t3 flush beat", bus.out_data, 64'h0000_0000_0006_0005);
        check("t3 flush keep", bus.out_keep, 4'b0011);
        check("t3 run in_ready", bus.in_ready, 1'b1);

        // Backpressure while input is pending.
        pkt_q = '{4'b1111, 4'b1111, 4'b1111};
        model_packet();
        drive_mask(4'b1111, 1'b0);
        bus.out_ready = 1'b0;
        bus.in_data   = 4'b1111;
        bus.in_last   = 1'b0;
        bus.in_valid  = 1'b1;
        repeat (5) begin
            @(negedge clk);
            check("t4 in_ready held", bus.in_ready, 1'b0);
            check("t4 out_valid held", bus.out_valid, 1'b1);
        end
        @(posedge clk);
        #1;
        bus.out_ready = 1'b1;
        drive_mask(4'b1111, 1'b0);
        drive_mask(4'b1111, 1'b1);

        // Base restarts at zero for each packet.
        pkt_q = '{4'b0001, 4'b0001};
        send_packet(1'b0);
        pkt_q = '{4'b0001};
        send_packet(1'b0);
        check("t5 packet B data", bus.out_data, 64'd0);
        check("t5 packet B keep", bus.out_keep, 4'b0001);

        // Reset mid-packet discards the residue.
        @(posedge clk);
        #1;
        drive_mask(4'b0011, 1'b0);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        check("t6 out_valid after rst", bus.out_valid, 1'b0);
        pkt_q = '{4'b1000};
        send_packet(1'b0);
        check("t6 data", bus.out_data, 64'h0000_0000_0000_0003);
        check("t6 keep", bus.out_keep, 4'b0001);
        check("t6 last", bus.out_last, 1'b1);

        // Random packets under random backpressure.
        rand_ready = 1'b1;
        for (int p = 0; p < 60; p++) begin
            int len;
            pkt_q.delete();
            len = $urandom_range(1, 5);
            for (int k = 0; k < len; k++) begin
                case ($urandom_range(0, 3))
                    0:       pkt_q.push_back(4'b0000);
                    1:       pkt_q.push_back(4'b1111);
                    default: pkt_q.push_back(4'($urandom_range(0, 15)));
                endcase
            end
            send_packet(1'b1);
        end

        rand_ready = 1'b0;
        @(posedge clk);
        #1;
        bus.out_ready = 1'b1;
        guard = 0;
        while (exp_q.size() > 0 && guard < 2000) begin
            @(posedge clk);
            guard++;
        end
        @(negedge clk);
        check("drain remaining", 64'(exp_q.size()), 64'd0);
        check("idle out_valid", bus.out_valid, 1'b0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
